// File: rtl/demux_seq_pkg.sv
// Shared types and helpers for the demux select sequencer.
//   state_t   : sequencer FSM states (IDLE, ROUTE)
//   MODE_*    : channel-selection modes sampled at beat accept
//   sel_w()   : select/counter width for a given count (minimum 1 bit)
package demux_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ROUTE = 1'b1
    } state_t;

    localparam logic MODE_RR   = 1'b0;
    localparam logic MODE_ADDR = 1'b1;

    // Width needed to hold values 0..n-1; never narrower than one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_rr_ptr.sv
// Wrapping round-robin pointer 0..N-1.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance pointer by one, wrapping N-1 -> 0
//   ptr        : current pointer (registered)
//   last_c     : combinational flag, ptr == N-1
module demux_rr_ptr
    import demux_seq_pkg::*;
#(
    parameter  int unsigned N = 4,
    localparam int unsigned W = sel_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] ptr,
    output logic         last_c
);

    assign last_c = (ptr == W'(N - 1));

    // Pointer register; wraps explicitly so non-power-of-2 N stays in range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= last_c ? '0 : ptr + W'(1);
        end
    end

endmodule

// File: rtl/demux_sel_sequencer.sv
// Upstream driver for a 1xN demux: takes 1-bit beats on a valid/ready
// stream and drives registered en/i/s, one channel per beat, holding each
// routed beat for HOLD_CYC cycles.
// Optional feature: define DEMUX_SEQ_ERRCNT_EN to add the saturating
// err_cnt port counting dropped (bad-address) beats.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : beat present
//   in_data     : beat value, forwarded to i
//   in_addr     : target channel in addressed mode
//   mode        : 0 round-robin, 1 addressed; sampled at accept
//   in_ready    : combinational, high while idle
//   en, i, s    : registered demux enable / data / select
//   frame_done  : pulse when the RR beat for channel N-1 goes out
//   addr_err    : pulse when an addressed beat with in_addr >= N is dropped
//   err_cnt     : dropped-beat count (DEMUX_SEQ_ERRCNT_EN only)
module demux_sel_sequencer
    import demux_seq_pkg::*;
#(
    parameter  int unsigned N        = 4,
    parameter  int unsigned HOLD_CYC = 1,
    localparam int unsigned SEL_W    = sel_w(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_data,
    input  logic [SEL_W-1:0] in_addr,
    input  logic             mode,
    output logic             in_ready,
    output logic             en,
    output logic             i,
    output logic [SEL_W-1:0] s,
    output logic             frame_done,
    output logic             addr_err
`ifdef DEMUX_SEQ_ERRCNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam int unsigned HC_W = sel_w(HOLD_CYC);

    state_t           state;
    logic [HC_W-1:0]  hold_cnt;
    logic [SEL_W-1:0] rr_ptr;
    logic             rr_last_c;
    logic             accept_c;
    logic             bad_addr_c;
    logic             rr_inc_c;
    logic [SEL_W-1:0] chan_c;

    assign in_ready   = (state == IDLE);
    assign accept_c   = in_valid & in_ready;
    // Only reachable for non-power-of-2 N; widened compare avoids truncation.
    assign bad_addr_c = (mode == MODE_ADDR) && (32'(in_addr) >= N);
    assign rr_inc_c   = accept_c & (mode == MODE_RR);
    assign chan_c     = (mode == MODE_ADDR) ? in_addr : rr_ptr;

    demux_rr_ptr #(.N(N)) u_rr_ptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (rr_inc_c),
        .ptr    (rr_ptr),
        .last_c (rr_last_c)
    );

    // Sequencer FSM with registered demux drive and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            en         <= 1'b0;
            i          <= 1'b0;
            s          <= '0;
            frame_done <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            addr_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        if (bad_addr_c) begin
                            // Beat consumed but never reaches the demux.
                            addr_err <= 1'b1;
                        end else begin
                            state      <= ROUTE;
                            hold_cnt   <= '0;
                            en         <= 1'b1;
                            i          <= in_data;
                            s          <= chan_c;
                            frame_done <= rr_inc_c & rr_last_c;
                        end
                    end
                end
                ROUTE: begin
                    if (hold_cnt == HC_W'(HOLD_CYC - 1)) begin
                        // i and s keep their last value while en is low.
                        state    <= IDLE;
                        hold_cnt <= '0;
                        en       <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DEMUX_SEQ_ERRCNT_EN
    // Saturating count of dropped beats; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (accept_c && bad_addr_c && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Self-checking bench for demux_sel_sequencer. Three instances share the
// input stream: [0] N=4/HOLD=1, [1] N=3/HOLD=1, [2] N=4/HOLD=3.
// Honours DEMUX_SEQ_ERRCNT_EN when the err_cnt port is built.
module tb_demux_sel_sequencer;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_data  = 1'b0;
    logic       mode     = 1'b0;
    logic [1:0] in_addr  = 2'd0;

    logic       rdy [3];
    logic       en  [3];
    logic       io  [3];
    logic [1:0] s   [3];
    logic       fd  [3];
    logic       ae  [3];
    logic [7:0] ec  [3];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state, one slot per instance.
    int NP [3] = '{4, 3, 4};
    int HP [3] = '{1, 1, 3};
    int m_busy [3];
    int m_ptr  [3];
    int m_s    [3];
    int m_err  [3];
    bit m_en   [3];
    bit m_i    [3];
    bit m_fd   [3];
    bit m_ae   [3];

    always #5 clk = ~clk;

    demux_sel_sequencer #(.N(4), .HOLD_CYC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_addr(in_addr), .mode(mode), .in_ready(rdy[0]), .en(en[0]),
        .i(io[0]), .s(s[0]), .frame_done(fd[0]), .addr_err(ae[0])
`ifdef DEMUX_SEQ_ERRCNT_EN
        , .err_cnt(ec[0])
`endif
    );

    demux_sel_sequencer #(.N(3), .HOLD_CYC(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_addr(in_addr), .mode(mode), .in_ready(rdy[1]), .en(en[1]),
        .i(io[1]), .s(s[1]), .frame_done(fd[1]), .addr_err(ae[1])
`ifdef DEMUX_SEQ_ERRCNT_EN
        , .err_cnt(ec[1])
`endif
    );

    demux_sel_sequencer #(.N(4), .HOLD_CYC(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_addr(in_addr), .mode(mode), .in_ready(rdy[2]), .en(en[2]),
        .i(io[2]), .s(s[2]), .frame_done(fd[2]), .addr_err(ae[2])
`ifdef DEMUX_SEQ_ERRCNT_EN
        , .err_cnt(ec[2])
`endif
    );

`ifndef DEMUX_SEQ_ERRCNT_EN
    initial for (int k = 0; k < 3; k++) ec[k] = 8'd0;
`endif

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_busy[d] = 0; m_ptr[d] = 0; m_s[d] = 0; m_err[d] = 0;
            m_en[d] = 0; m_i[d] = 0; m_fd[d] = 0; m_ae[d] = 0;
        end
    endtask

    // Predict every instance's outputs after the next rising edge.
    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            bit ready;
            ready = (m_busy[d] == 0);
            m_fd[d] = 0;
            m_ae[d] = 0;
            if (ready && in_valid) begin
                if (mode && (int'(in_addr) >= NP[d])) begin
                    m_ae[d] = 1;
                    if (m_err[d] < 255) m_err[d]++;
                end else begin
                    m_i[d] = in_data;
                    if (mode) begin
                        m_s[d] = int'(in_addr);
                    end else begin
                        m_s[d]   = m_ptr[d];
                        m_fd[d]  = (m_ptr[d] == NP[d] - 1);
                        m_ptr[d] = (m_ptr[d] + 1) % NP[d];
                    end
                    m_busy[d] = HP[d];
                end
            end else if (m_busy[d] > 0) begin
                m_busy[d]--;
            end
            m_en[d] = (m_busy[d] > 0);
        end
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; in_data = 1'b0; in_addr = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; in_data = 1'b1; mode = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (en[d] !== 1'b0 || io[d] !== 1'b0 || s[d] !== 2'd0 || rdy[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got en=%0d i=%0d s=%0d rdy=%0d want 0 0 0 1",
                         d, en[d], io[d], s[d], rdy[d]);
            end
        end
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (en[d] !== 1'b0 || rdy[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_release[%0d]: got en=%0d rdy=%0d want 0 1", d, en[d], rdy[d]);
            end
        end
    endtask

    task automatic test_rr_frame();
        logic dat [5];
        dat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        reset_all();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = dat[k]; mode = 1'b0;
            @(negedge clk);
            in_valid = 1'b0;
            n_cmp++;
            if (en[0] !== 1'b1 || s[0] !== 2'(k % 4) || io[0] !== dat[k] ||
                fd[0] !== (k == 3) || rdy[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_beat%0d: got en=%0d s=%0d i=%0d fd=%0d rdy=%0d want 1 %0d %0d %0d 0",
                         k, en[0], s[0], io[0], fd[0], rdy[0], k % 4, dat[k], k == 3);
            end
            @(negedge clk);
            n_cmp++;
            if (en[0] !== 1'b0 || fd[0] !== 1'b0 || rdy[0] !== 1'b1 || s[0] !== 2'(k % 4)) begin
                n_fail++;
                $display("FAIL rr_gap%0d: got en=%0d fd=%0d rdy=%0d s=%0d want 0 0 1 %0d",
                         k, en[0], fd[0], rdy[0], s[0], k % 4);
            end
        end
    endtask

    task automatic test_addressed();
        logic [1:0] adr [3];
        adr = '{2'd2, 2'd0, 2'd3};
        reset_all();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 1'b1; mode = 1'b1; in_addr = adr[k];
            @(negedge clk);
            in_valid = 1'b0;
            n_cmp++;
            if (en[0] !== 1'b1 || s[0] !== adr[k] || io[0] !== 1'b1 || fd[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL addr_beat%0d: got en=%0d s=%0d i=%0d fd=%0d want 1 %0d 1 0",
                         k, en[0], s[0], io[0], fd[0], adr[k]);
            end
            @(negedge clk);
        end
        // Round-robin pointer must still be at 0.
        in_valid = 1'b1; in_data = 1'b0; mode = 1'b0; in_addr = 2'd3;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (en[0] !== 1'b1 || s[0] !== 2'd0 || io[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL addr_rr_ptr: got en=%0d s=%0d i=%0d want 1 0 0", en[0], s[0], io[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_bad_addr();
        reset_all();
        in_valid = 1'b1; in_data = 1'b1; mode = 1'b1; in_addr = 2'd3;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (en[1] !== 1'b0 || ae[1] !== 1'b1 || rdy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_addr: got en=%0d ae=%0d rdy=%0d want 0 1 1", en[1], ae[1], rdy[1]);
        end
`ifdef DEMUX_SEQ_ERRCNT_EN
        n_cmp++;
        if (ec[1] !== 8'd1) begin
            n_fail++;
            $display("FAIL err_cnt_one: got %0d want 1", ec[1]);
        end
`endif
        @(negedge clk);
        n_cmp++;
        if (ae[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_addr_pulse: got ae=%0d want 0", ae[1]);
        end
        in_valid = 1'b1;
        repeat (300) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ae[1] !== 1'b0 || en[1] !== 1'b0 || rdy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_addr_burst: got ae=%0d en=%0d rdy=%0d want 0 0 1", ae[1], en[1], rdy[1]);
        end
`ifdef DEMUX_SEQ_ERRCNT_EN
        n_cmp++;
        if (ec[1] !== 8'hFF) begin
            n_fail++;
            $display("FAIL err_cnt_sat: got %0d want 255", ec[1]);
        end
`endif
        in_valid = 1'b1; mode = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (en[1] !== 1'b1 || s[1] !== 2'd0) begin
            n_fail++;
            $display("FAIL bad_addr_rr: got en=%0d s=%0d want 1 0", en[1], s[1]);
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        int en_hi;
        int busy;
        en_hi = 0; busy = 0;
        reset_all();
        in_valid = 1'b1; in_data = 1'b1; mode = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (en[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_first: got en=%0d want 1", en[2]);
        end
        for (int c = 0; c < 6; c++) begin
            if (en[2] === 1'b1) en_hi++;
            if (rdy[2] === 1'b0) busy++;
            @(negedge clk);
        end
        n_cmp++;
        if (en_hi != 3 || busy != 3) begin
            n_fail++;
            $display("FAIL hold_len: got en_cycles=%0d busy_cycles=%0d want 3 3", en_hi, busy);
        end
    endtask

    task automatic test_mid_hold_reset();
        reset_all();
        in_valid = 1'b1; in_data = 1'b1; mode = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (en[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_hold_pre: got en=%0d want 1", en[2]);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (en[2] !== 1'b0 || rdy[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_hold_abort: got en=%0d rdy=%0d want 0 1", en[2], rdy[2]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 1'b1; mode = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (en[2] !== 1'b1 || s[2] !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_hold_next: got en=%0d s=%0d want 1 0", en[2], s[2]);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        reset_all();
        @(negedge clk);
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if (en[d] !== m_en[d] || io[d] !== m_i[d] || s[d] !== 2'(m_s[d]) ||
                    fd[d] !== m_fd[d] || ae[d] !== m_ae[d] || rdy[d] !== (m_busy[d] == 0)) begin
                    n_fail++;
                    $display("FAIL rand[%0d] cyc%0d: got en=%0d i=%0d s=%0d fd=%0d ae=%0d rdy=%0d want %0d %0d %0d %0d %0d %0d",
                             d, c, en[d], io[d], s[d], fd[d], ae[d], rdy[d],
                             m_en[d], m_i[d], m_s[d], m_fd[d], m_ae[d], m_busy[d] == 0);
                end
`ifdef DEMUX_SEQ_ERRCNT_EN
                n_cmp++;
                if (ec[d] !== 8'(m_err[d])) begin
                    n_fail++;
                    $display("FAIL rand_err_cnt[%0d] cyc%0d: got %0d want %0d", d, c, ec[d], m_err[d]);
                end
`endif
            end
            in_valid = ($urandom_range(0, 9) < 7);
            in_data  = 1'($urandom);
            mode     = 1'($urandom);
            in_addr  = 2'($urandom_range(0, 3));
            model_step();
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rr_frame();
        test_addressed();
        test_bad_addr();
        test_hold();
        test_mid_hold_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
